// File: rtl/maze_round_ctrl.sv
// rtl/maze_round_ctrl.sv - maze game round sequencer: idle/carve/arm/play/win flow, round timer, best time
module maze_round_ctrl #(
  parameter int CLK_PER_SEC   = 50_000_000,
  parameter int CARVE_TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       carve_finished,
  input  logic [3:0] player_x,
  input  logic [3:0] player_y,
  input  logic [3:0] finish_x,
  input  logic [3:0] finish_y,
  output logic       carve_start,
  output logic       carving,
  output logic       move_reset,
  output logic       move_enable,
  output logic       won,
  output logic [9:0] elapsed_sec,
  output logic [9:0] best_sec,
  output logic       best_valid,
  output logic       new_record,
  output logic       carve_error,
  output logic [2:0] state
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int TW = (CARVE_TIMEOUT > 1) ? $clog2(CARVE_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CARVE_TIMEOUT - 1);
  localparam logic [9:0]    SEC_MAX  = 10'd999;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CARVE = 3'd1,
    S_ARM   = 3'd2,
    S_PLAY  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic          armed_q, armed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    elapsed_d, best_d;
  logic          best_valid_d, new_record_d, carve_error_d, carve_start_d;
  logic          start_edge, goal, carve_done, carve_tmo, presc_wrap;

  assign start_edge = start_btn & ~start_q;
  assign goal       = (player_x == finish_x) && (player_y == finish_y);
  // a done level is trusted only after the carver was seen busy during this visit
  assign carve_done = armed_q & carve_finished;
  assign carve_tmo  = (tmo_q == TMO_LAST);
  assign presc_wrap = (presc_q == PRE_LAST);
  assign state      = state_q;

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    presc_d       = presc_q;
    tmo_d         = tmo_q;
    elapsed_d     = elapsed_sec;
    best_d        = best_sec;
    best_valid_d  = best_valid;
    new_record_d  = 1'b0;
    carve_error_d = carve_error;
    carve_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_CARVE;
      end
      S_CARVE: begin
        tmo_d = tmo_q + 1'b1;
        if (!carve_finished) armed_d = 1'b1;
        if (carve_done) begin
          state_d = S_ARM;
        end else if (carve_tmo) begin
          state_d       = S_IDLE;
          carve_error_d = 1'b1;
        end
      end
      S_ARM: begin
        presc_d   = '0;
        elapsed_d = '0;
        state_d   = S_PLAY;
      end
      S_PLAY: begin
        if (goal) begin
          state_d = S_WIN;
          if (!best_valid || (elapsed_sec < best_sec)) begin
            best_d       = elapsed_sec;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
          end
        end else begin
          presc_d = presc_wrap ? '0 : presc_q + 1'b1;
          if (presc_wrap && (elapsed_sec != SEC_MAX)) elapsed_d = elapsed_sec + 10'd1;
          if (start_edge) state_d = S_CARVE;
        end
      end
      S_WIN: begin
        if (start_edge) state_d = S_CARVE;
      end
      default: state_d = S_IDLE;
    endcase
    // every fresh CARVE visit starts from a clean timeout and arm history
    if ((state_d == S_CARVE) && (state_q != S_CARVE)) begin
      carve_start_d = 1'b1;
      carve_error_d = 1'b0;
      tmo_d         = '0;
      armed_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      presc_q     <= '0;
      tmo_q       <= '0;
      elapsed_sec <= '0;
      best_sec    <= '0;
      best_valid  <= 1'b0;
      new_record  <= 1'b0;
      carve_error <= 1'b0;
      carve_start <= 1'b0;
      carving     <= 1'b0;
      move_reset  <= 1'b0;
      move_enable <= 1'b0;
      won         <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_btn;
      armed_q     <= armed_d;
      presc_q     <= presc_d;
      tmo_q       <= tmo_d;
      elapsed_sec <= elapsed_d;
      best_sec    <= best_d;
      best_valid  <= best_valid_d;
      new_record  <= new_record_d;
      carve_error <= carve_error_d;
      carve_start <= carve_start_d;
      carving     <= (state_d == S_CARVE);
      move_reset  <= (state_d == S_ARM);
      move_enable <= (state_d == S_PLAY);
      won         <= (state_d == S_WIN);
    end
  end

endmodule

// File: tb/tb_maze_round_ctrl.sv
// tb/tb_maze_round_ctrl.sv - self-checking bench for maze_round_ctrl
module tb_maze_round_ctrl;

  localparam int CPS = 10;
  localparam int CTO = 50;

  logic       clk, reset, start_btn, carve_finished;
  logic [3:0] player_x, player_y, finish_x, finish_y;
  logic       carve_start, carving, move_reset, move_enable, won;
  logic [9:0] elapsed_sec, best_sec;
  logic       best_valid, new_record, carve_error;
  logic [2:0] state;

  int vectors;
  int miscompares;
  int model_best;
  bit model_valid;

  maze_round_ctrl #(.CLK_PER_SEC(CPS), .CARVE_TIMEOUT(CTO)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .carve_finished(carve_finished),
    .player_x(player_x), .player_y(player_y), .finish_x(finish_x), .finish_y(finish_y),
    .carve_start(carve_start), .carving(carving), .move_reset(move_reset),
    .move_enable(move_enable), .won(won), .elapsed_sec(elapsed_sec), .best_sec(best_sec),
    .best_valid(best_valid), .new_record(new_record), .carve_error(carve_error), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
  endtask

  task automatic carve_ok();
    player_x = 4'd0;
    player_y = 4'd0;
    carve_finished = 1'b0;
    tick();
    carve_finished = 1'b1;
    tick();
    tick();
  endtask

  task automatic play_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      player_x = 4'($urandom_range(0, 14));
      player_y = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic reach_goal();
    player_x = finish_x;
    player_y = finish_y;
    tick();
  endtask

  function automatic int exp_secs(input int play_n);
    int s;
    s = play_n / CPS;
    return (s > 999) ? 999 : s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++;
    if ({carve_start, carving, move_reset, move_enable, won, new_record, carve_error, best_valid} !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000000",
        {carve_start, carving, move_reset, move_enable, won, new_record, carve_error, best_valid});
    end
    vectors++;
    if ({elapsed_sec, best_sec} !== 20'd0) begin
      miscompares++; $display("FAIL reset_times: got elapsed %0d best %0d expected 0 0", elapsed_sec, best_sec);
    end
    reset = 1'b0;
  endtask

  task automatic test_start_edge();
    int pulses;
    pulses = 0;
    carve_finished = 1'b1;
    tick();
    start_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(carve_start);
      if (i == 0) begin
        vectors++;
        if (state !== 3'd1 || carving !== 1'b1) begin
          miscompares++; $display("FAIL start_enter_carve: got state %0d carving %0b expected 1 1", state, carving);
        end
      end
    end
    start_btn = 1'b0;
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL start_single_pulse: got %0d pulses expected 1", pulses); end
    vectors++;
    if (state !== 3'd1) begin miscompares++; $display("FAIL stale_done_ignored: got state %0d expected 1", state); end
  endtask

  task automatic test_arm();
    carve_finished = 1'b0;
    tick();
    vectors++;
    if (state !== 3'd1) begin miscompares++; $display("FAIL arm_low_stays: got state %0d expected 1", state); end
    carve_finished = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd2 || move_reset !== 1'b1) begin
      miscompares++; $display("FAIL arm_entry: got state %0d move_reset %0b expected 2 1", state, move_reset);
    end
    tick();
    vectors++;
    if (state !== 3'd3 || move_enable !== 1'b1 || move_reset !== 1'b0) begin
      miscompares++; $display("FAIL play_entry: got state %0d en %0b mr %0b expected 3 1 0", state, move_enable, move_reset);
    end
  endtask

  task automatic test_first_round();
    play_cycles(35);
    reach_goal();
    vectors++;
    if (state !== 3'd4 || won !== 1'b1) begin
      miscompares++; $display("FAIL first_win: got state %0d won %0b expected 4 1", state, won);
    end
    vectors++;
    if (elapsed_sec !== 10'd3 || best_sec !== 10'd3 || best_valid !== 1'b1 || new_record !== 1'b1) begin
      miscompares++; $display("FAIL first_best: got e %0d b %0d v %0b nr %0b expected 3 3 1 1",
        elapsed_sec, best_sec, best_valid, new_record);
    end
    model_best = 3;
    model_valid = 1'b1;
    tick();
    vectors++;
    if (new_record !== 1'b0 || elapsed_sec !== 10'd3) begin
      miscompares++; $display("FAIL first_pulse_len: got nr %0b e %0d expected 0 3", new_record, elapsed_sec);
    end
  endtask

  task automatic test_slower_round();
    press_start();
    vectors++;
    if (state !== 3'd1 || carve_start !== 1'b1) begin
      miscompares++; $display("FAIL win_restart: got state %0d cs %0b expected 1 1", state, carve_start);
    end
    carve_ok();
    play_cycles(45);
    reach_goal();
    vectors++;
    if (elapsed_sec !== 10'd4 || best_sec !== 10'd3 || new_record !== 1'b0) begin
      miscompares++; $display("FAIL slower_round: got e %0d b %0d nr %0b expected 4 3 0", elapsed_sec, best_sec, new_record);
    end
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 8; r++) begin
      int n, e;
      bit rec;
      n = $urandom_range(0, 60);
      if (model_valid && ($urandom_range(0, 2) == 0)) n = model_best * CPS + $urandom_range(0, CPS - 1);
      e = exp_secs(n);
      rec = !model_valid || (e < model_best);
      if (rec) begin model_best = e; model_valid = 1'b1; end
      press_start();
      carve_ok();
      play_cycles(n);
      reach_goal();
      vectors++;
      if (elapsed_sec !== 10'(e) || best_sec !== 10'(model_best) || new_record !== rec || won !== 1'b1) begin
        miscompares++; $display("FAIL random_round%0d: got e %0d b %0d nr %0b won %0b expected %0d %0d %0b 1",
          r, elapsed_sec, best_sec, new_record, won, e, model_best, rec);
      end
    end
  endtask

  task automatic test_timeout();
    carve_finished = 1'b0;
    press_start();
    for (int i = 0; i < CTO - 1; i++) tick();
    vectors++;
    if (state !== 3'd1) begin miscompares++; $display("FAIL timeout_early: got state %0d expected 1", state); end
    tick();
    vectors++;
    if (state !== 3'd0 || carve_error !== 1'b1) begin
      miscompares++; $display("FAIL timeout_abort: got state %0d err %0b expected 0 1", state, carve_error);
    end
    press_start();
    vectors++;
    if (state !== 3'd1 || carve_start !== 1'b1 || carve_error !== 1'b0) begin
      miscompares++; $display("FAIL timeout_restart: got state %0d cs %0b err %0b expected 1 1 0", state, carve_start, carve_error);
    end
    for (int i = 0; i < CTO - 1; i++) tick();
    carve_finished = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd2 || carve_error !== 1'b0) begin
      miscompares++; $display("FAIL done_beats_timeout: got state %0d err %0b expected 2 0", state, carve_error);
    end
    player_x = 4'd0;
    tick();
  endtask

  task automatic test_goal_and_start();
    int e;
    bit rec;
    play_cycles(12);
    e = exp_secs(12);
    rec = !model_valid || (e < model_best);
    if (rec) begin model_best = e; model_valid = 1'b1; end
    player_x = finish_x;
    player_y = finish_y;
    start_btn = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd4 || carve_start !== 1'b0 || won !== 1'b1) begin
      miscompares++; $display("FAIL goal_over_start: got state %0d cs %0b won %0b expected 4 0 1", state, carve_start, won);
    end
    vectors++;
    if (elapsed_sec !== 10'(e) || new_record !== rec) begin
      miscompares++; $display("FAIL goal_over_start_time: got e %0d nr %0b expected %0d %0b", elapsed_sec, new_record, e, rec);
    end
    start_btn = 1'b0;
    tick();
    vectors++;
    if (state !== 3'd4) begin miscompares++; $display("FAIL held_start_no_edge: got state %0d expected 4", state); end
  endtask

  task automatic test_saturate();
    press_start();
    carve_ok();
    play_cycles(9989);
    vectors++;
    if (elapsed_sec !== 10'd998) begin miscompares++; $display("FAIL sat_below: got %0d expected 998", elapsed_sec); end
    play_cycles(11);
    vectors++;
    if (elapsed_sec !== 10'd999) begin miscompares++; $display("FAIL sat_reach: got %0d expected 999", elapsed_sec); end
    play_cycles(40);
    reach_goal();
    vectors++;
    if (elapsed_sec !== 10'd999 || best_sec !== 10'(model_best) || new_record !== 1'b0) begin
      miscompares++; $display("FAIL sat_win: got e %0d b %0d nr %0b expected 999 %0d 0", elapsed_sec, best_sec, new_record, model_best);
    end
  endtask

  task automatic test_reset_mid();
    press_start();
    carve_ok();
    play_cycles(25);
    vectors++;
    if (best_valid !== 1'b1 || move_enable !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_play: got v %0b en %0b expected 1 1", best_valid, move_enable);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (state !== 3'd0 || {carve_start, carving, move_reset, move_enable, won, new_record, carve_error, best_valid} !== 8'h00
        || elapsed_sec !== 10'd0 || best_sec !== 10'd0) begin
      miscompares++; $display("FAIL mid_reset: got state %0d flags %b e %0d b %0d expected 0 00000000 0 0", state,
        {carve_start, carving, move_reset, move_enable, won, new_record, carve_error, best_valid}, elapsed_sec, best_sec);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (state !== 3'd0) begin miscompares++; $display("FAIL post_reset_idle: got state %0d expected 0", state); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_best = 0;
    model_valid = 1'b0;
    reset = 1'b1;
    start_btn = 1'b0;
    carve_finished = 1'b0;
    player_x = 4'd0;
    player_y = 4'd0;
    finish_x = 4'd15;
    finish_y = 4'd15;
    test_reset();
    test_start_edge();
    test_arm();
    test_first_round();
    test_slower_round();
    test_random_rounds();
    test_timeout();
    test_goal_and_start();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_round_ctrl.md
Name: maze_round_ctrl

Overview:
- Round sequencer for the maze game: owns the idle → carve → arm → play → win flow that drives the maze carver, the player-move block and the renderer enable.
- Times each play round in seconds, keeps the best time, and detects a stalled carver.
- Sits between the button/keyboard inputs and the carver, mover and renderer in the FPGA top level. Replaces the simple state decoder.

Parameters:
- CLK_PER_SEC, 50_000_000: clk cycles per elapsed-time second (prescaler terminal count + 1).
- CARVE_TIMEOUT, 100_000_000: maximum clk cycles spent in CARVE before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  debounced, clk-synchronous start/new-maze button (level)
- carve_finished  in  1  carver done flag (level)
- player_x  in  4  player tile column
- player_y  in  4  player tile row
- finish_x  in  4  goal tile column
- finish_y  in  4  goal tile row
- carve_start  out  1  one-cycle pulse: begin carving
- carving  out  1  high throughout CARVE (renderer enable)
- move_reset  out  1  one-cycle pulse: return player to start tile
- move_enable  out  1  high throughout PLAY
- won  out  1  high throughout WIN
- elapsed_sec  out  10  seconds in current/last round, saturating at 999
- best_sec  out  10  best completed-round time
- best_valid  out  1  best_sec holds a real result
- new_record  out  1  one-cycle pulse when best_sec is updated
- carve_error  out  1  sticky: last carve timed out; cleared by next start edge
- state  out  3  encoding: IDLE=0, CARVE=1, ARM=2, PLAY=3, WIN=4

Behaviour:
- All outputs are registered. Reset (synchronous, takes effect at the clk edge, overrides everything):
  - state=IDLE.
  - All pulses/levels 0, elapsed_sec=0, best_sec=0, best_valid=0, carve_error=0.
  - Prescaler, timeout counter and the button history register all cleared.
- start_edge = start_btn & ~start_q, where start_q is start_btn registered each cycle. A held button gives exactly one edge.
- IDLE:
  - On start_edge → CARVE.
  - carve_start=1 in the first CARVE cycle only. carve_error cleared on the same edge.
- CARVE:
  - carving=1. Timeout counter increments each cycle from 0.
  - carve_finished is qualified only after it has been sampled 0 at least once in this CARVE visit (arm flag). This rejects a stale done level from the previous maze.
  - Qualified carve_finished=1 → ARM.
  - Otherwise, counter == CARVE_TIMEOUT-1 → IDLE with carve_error=1.
  - If both happen in the same cycle, finished wins.
  - start_edge is ignored in CARVE.
- ARM (exactly one cycle):
  - move_reset=1. elapsed_sec and prescaler cleared.
  - Next state is PLAY.
- PLAY:
  - move_enable=1. Prescaler counts 0..CLK_PER_SEC-1 and wraps.
  - On wrap, elapsed_sec += 1, unless already 999 (it then holds 999).
  - (player_x,player_y) == (finish_x,finish_y) → WIN; elapsed_sec freezes.
  - Else start_edge → CARVE (abandon round, carve_start pulse, best unchanged).
  - Goal match and start_edge in the same cycle: WIN has priority and start_edge is dropped.
  - A goal match is evaluated only in PLAY, never in ARM, so a finish tile equal to the start tile wins one cycle after ARM.
- Transition PLAY→WIN (same edge):
  - If !best_valid or elapsed_sec < best_sec: best_sec ← elapsed_sec, best_valid ← 1, new_record=1 for one cycle (the first WIN cycle).
  - A tie does not update and gives no pulse.
- WIN:
  - won=1. elapsed_sec holds.
  - start_edge → CARVE with carve_start pulse.
- Output levels are decoded from the registered state, so they change on the same edge as the state.
- No path from CARVE back to PLAY without passing through ARM.
- Prescaler and timeout counter widths: clog2 of their parameter.
- Counters hold when not in their state.

Test Plan:
All scenarios use CLK_PER_SEC=10 and CARVE_TIMEOUT=50.
- Reset, then pulse start_btn high for 5 cycles → state=1, carve_start high exactly 1 cycle, carving=1, a single edge only.
- In CARVE, hold carve_finished=1 from entry; drop it to 0 for 1 cycle, then raise it → ARM only after the re-raise. move_reset is a 1-cycle pulse, then state=3 with move_enable=1.
- Stay in PLAY 35 cycles, then set player=finish=(15,15) → elapsed_sec=3, won=1, best_sec=3, best_valid=1, new_record 1 cycle. A second round with a 4-second time → best_sec stays 3, no new_record.
- In CARVE, keep carve_finished=0 for 50 cycles → state=0 and carve_error=1. The next start edge clears carve_error and pulses carve_start.
- In PLAY, assert start edge on the same cycle the goal is matched → state=4 (WIN), no carve_start. Stay in PLAY 10_000 cycles → elapsed_sec saturates at 999.
- Assert reset mid-PLAY with best_valid=1 → next cycle state=0, all outputs 0, best_valid=0.
